tick_stopwatch: RTL and testbench

TICK_STOPWATCH -- requirements
Module: tick_stopwatch

---
 rtl/tick_stopwatch.sv | 154 +++++++++++++++
 tb/tb_tick_stopwatch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tick_stopwatch.sv
// MM:SS stopwatch counting TICKS_PER_SEC tick_in rising edges per second, with start/pause and clear buttons.
// Optional STOPWATCH_SEG_EN adds registered active-low 7-segment outputs seg0..seg3.
module tick_stopwatch #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start_btn,
  input  logic       clr_btn,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       running,
  output logic       wrap
`ifdef STOPWATCH_SEG_EN
  ,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [15:0] SUB_MAX = 16'(TICKS_PER_SEC - 1);

  state_t      state_reg, state_next;
  logic        tick_q, start_q, clr_q;
  logic        tick_rise, start_press, clr_press;
  logic        advance, sec_done;
  logic [15:0] sub_cnt_reg, sub_cnt_next;
  logic [3:0]  dig_reg  [4];
  logic [3:0]  dig_next [4];
  logic        wrap_reg, wrap_next;
  logic        running_reg;

  assign tick_rise   = tick_in & ~tick_q;
  assign start_press = start_btn & ~start_q;
  assign clr_press   = clr_btn & ~clr_q;
  assign advance     = (state_reg == RUN) && tick_rise;
  assign sec_done    = advance && (sub_cnt_reg == SUB_MAX);

  always_comb begin
    state_next = state_reg;
    if (clr_press) begin
      state_next = IDLE;
    end else if (start_press) begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Digit order 0..3 = sec_lo, sec_hi, min_lo, min_hi; tens digits roll at 5.
  always_comb begin
    logic carry;
    sub_cnt_next = sub_cnt_reg;
    wrap_next    = 1'b0;
    carry        = sec_done;
    for (int i = 0; i < 4; i++) begin
      dig_next[i] = dig_reg[i];
      if (carry) begin
        if (dig_reg[i] >= ((i % 2 == 1) ? 4'd5 : 4'd9)) begin
          dig_next[i] = 4'd0;
        end else begin
          dig_next[i] = dig_reg[i] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (advance) begin
      sub_cnt_next = sec_done ? 16'd0 : sub_cnt_reg + 16'd1;
    end
    wrap_next = carry;
    if (clr_press) begin
      sub_cnt_next = 16'd0;
      wrap_next    = 1'b0;
      for (int i = 0; i < 4; i++) dig_next[i] = 4'd0;
    end
  end

  // Button history resets high so a button held through reset is not a press.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      tick_q      <= 1'b0;
      start_q     <= 1'b1;
      clr_q       <= 1'b1;
      sub_cnt_reg <= 16'd0;
      wrap_reg    <= 1'b0;
      running_reg <= 1'b0;
      for (int i = 0; i < 4; i++) dig_reg[i] <= 4'd0;
    end else begin
      state_reg   <= state_next;
      tick_q      <= tick_in;
      start_q     <= start_btn;
      clr_q       <= clr_btn;
      sub_cnt_reg <= sub_cnt_next;
      wrap_reg    <= wrap_next;
      running_reg <= (state_next == RUN);
      for (int i = 0; i < 4; i++) dig_reg[i] <= dig_next[i];
    end
  end

  assign sec_lo  = dig_reg[0];
  assign sec_hi  = dig_reg[1];
  assign min_lo  = dig_reg[2];
  assign min_hi  = dig_reg[3];
  assign running = running_reg;
  assign wrap    = wrap_reg;

`ifdef STOPWATCH_SEG_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [6:0] seg_reg [4];

  // Decode the next digit values so segments change on the same edge as the digits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_seg
      always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) seg_reg[gi] <= 7'b1000000;
        else        seg_reg[gi] <= seg7(dig_next[gi]);
      end
    end
  endgenerate

  assign seg0 = seg_reg[0];
  assign seg1 = seg_reg[1];
  assign seg2 = seg_reg[2];
  assign seg3 = seg_reg[3];
`endif

endmodule

// File: tb/tb_tick_stopwatch.sv
// Directed testbench for tick_stopwatch with TICKS_PER_SEC = 4; define STOPWATCH_SEG_EN to cover the segment outputs.
module tb_tick_stopwatch;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       start_btn = 1'b0;
  logic       clr_btn = 1'b0;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
  logic       running, wrap;
`ifdef STOPWATCH_SEG_EN
  logic [6:0] seg0, seg1, seg2, seg3;
`endif

  int compared   = 0;
  int mismatched = 0;
  int wrap_cnt   = 0;

  tick_stopwatch #(.TICKS_PER_SEC(4)) dut (
    .clkin(clkin), .rst_n(rst_n), .tick_in(tick_in),
    .start_btn(start_btn), .clr_btn(clr_btn),
    .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
    .running(running), .wrap(wrap)
`ifdef STOPWATCH_SEG_EN
    , .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3)
`endif
  );

  always #10 clkin = ~clkin;

  always @(negedge clkin) if (wrap === 1'b1) wrap_cnt = wrap_cnt + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clkin); tick_in = 1'b1;
      @(negedge clkin); tick_in = 1'b0;
    end
  endtask

  task automatic press_start();
    @(negedge clkin); start_btn = 1'b1;
    @(negedge clkin); start_btn = 1'b0;
  endtask

  task automatic press_clr();
    @(negedge clkin); clr_btn = 1'b1;
    @(negedge clkin); clr_btn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clkin);
    compared++; if ({min_hi, min_lo, sec_hi, sec_lo} !== 16'h0000) begin mismatched++; $display("FAIL reset_digits: got %h want 0000", {min_hi, min_lo, sec_hi, sec_lo}); end
    compared++; if (running !== 1'b0) begin mismatched++; $display("FAIL reset_running: got %b want 0", running); end
    compared++; if (wrap !== 1'b0) begin mismatched++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    compared++; if (dut.sub_cnt_reg !== 16'd0) begin mismatched++; $display("FAIL reset_sub_cnt: got %0d want 0", dut.sub_cnt_reg); end
`ifdef STOPWATCH_SEG_EN
    compared++; if (seg0 !== 7'b1000000) begin mismatched++; $display("FAIL reset_seg0: got %b want 1000000", seg0); end
`endif
    @(negedge clkin); rst_n = 1'b1;
    $display("reset: done, %0d mismatched so far", mismatched);
  endtask

  task automatic test_count();
    tick(2);
    compared++; if (sec_lo !== 4'd0) begin mismatched++; $display("FAIL idle_ticks_ignored: got %0d want 0", sec_lo); end
    press_start();
    compared++; if (running !== 1'b1) begin mismatched++; $display("FAIL count_running_start: got %b want 1", running); end
    tick(8);
    compared++; if (sec_lo !== 4'd2) begin mismatched++; $display("FAIL count_sec_lo: got %0d want 2", sec_lo); end
    compared++; if (sec_hi !== 4'd0) begin mismatched++; $display("FAIL count_sec_hi: got %0d want 0", sec_hi); end
    compared++; if (running !== 1'b1) begin mismatched++; $display("FAIL count_running: got %b want 1", running); end
    compared++; if (dut.sub_cnt_reg !== 16'd0) begin mismatched++; $display("FAIL count_sub_cnt: got %0d want 0", dut.sub_cnt_reg); end
    $display("count: 8 ticks -> %0d%0d:%0d%0d", min_hi, min_lo, sec_hi, sec_lo);
  endtask

  task automatic test_pause();
    int frozen_bad;
    frozen_bad = 0;
    press_clr();
    compared++; if (sec_lo !== 4'd0 || running !== 1'b0) begin mismatched++; $display("FAIL pause_clear: got sec_lo=%0d running=%b want 0/0", sec_lo, running); end
    press_start();
    tick(5);
    compared++; if (sec_lo !== 4'd1) begin mismatched++; $display("FAIL pause_pre_sec_lo: got %0d want 1", sec_lo); end
    press_start();
    compared++; if (running !== 1'b0) begin mismatched++; $display("FAIL pause_running: got %b want 0", running); end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (sec_lo !== 4'd1 || dut.sub_cnt_reg !== 16'd1) frozen_bad++;
    end
    compared++; if (frozen_bad !== 0) begin mismatched++; $display("FAIL pause_frozen: got %0d changed samples want 0", frozen_bad); end
    press_start();
    compared++; if (running !== 1'b1) begin mismatched++; $display("FAIL pause_resume: got %b want 1", running); end
    tick(3);
    compared++; if (sec_lo !== 4'd2) begin mismatched++; $display("FAIL pause_post_sec_lo: got %0d want 2", sec_lo); end
    compared++; if (dut.sub_cnt_reg !== 16'd0) begin mismatched++; $display("FAIL pause_post_sub_cnt: got %0d want 0", dut.sub_cnt_reg); end
    $display("pause: 5+3 ticks around pause -> sec_lo=%0d", sec_lo);
  endtask

  task automatic test_start_on_last_tick();
    press_clr();
    press_start();
    tick(3);
    @(negedge clkin); tick_in = 1'b1; start_btn = 1'b1;
    @(negedge clkin); tick_in = 1'b0; start_btn = 1'b0;
    compared++; if (sec_lo !== 4'd1) begin mismatched++; $display("FAIL lasttick_sec_lo: got %0d want 1", sec_lo); end
    compared++; if (running !== 1'b0) begin mismatched++; $display("FAIL lasttick_running: got %b want 0", running); end
    compared++; if (dut.sub_cnt_reg !== 16'd0) begin mismatched++; $display("FAIL lasttick_sub_cnt: got %0d want 0", dut.sub_cnt_reg); end
    $display("start_on_last_tick: sec_lo=%0d running=%b", sec_lo, running);
  endtask

  task automatic test_clear();
    press_clr();
    press_start();
    tick(29);
    compared++; if (sec_lo !== 4'd7) begin mismatched++; $display("FAIL clear_pre_sec_lo: got %0d want 7", sec_lo); end
    @(negedge clkin); clr_btn = 1'b1; start_btn = 1'b1; tick_in = 1'b1;
    @(negedge clkin); clr_btn = 1'b0; start_btn = 1'b0; tick_in = 1'b0;
    compared++; if ({min_hi, min_lo, sec_hi, sec_lo} !== 16'h0000) begin mismatched++; $display("FAIL clear_digits: got %h want 0000", {min_hi, min_lo, sec_hi, sec_lo}); end
    compared++; if (running !== 1'b0) begin mismatched++; $display("FAIL clear_running: got %b want 0", running); end
    compared++; if (dut.sub_cnt_reg !== 16'd0) begin mismatched++; $display("FAIL clear_sub_cnt: got %0d want 0", dut.sub_cnt_reg); end
    tick(8);
    compared++; if (sec_lo !== 4'd0 || running !== 1'b0) begin mismatched++; $display("FAIL clear_ignored_ticks: got sec_lo=%0d running=%b want 0/0", sec_lo, running); end
    $display("clear: clear+start at 00:07 -> %0d%0d:%0d%0d", min_hi, min_lo, sec_hi, sec_lo);
  endtask

  task automatic test_hold_reset();
    press_start();
    tick(6);
    @(negedge clkin); rst_n = 1'b0; start_btn = 1'b1;
    @(negedge clkin);
    compared++; if (sec_lo !== 4'd0 || dut.sub_cnt_reg !== 16'd0) begin mismatched++; $display("FAIL midreset_progress: got sec_lo=%0d sub=%0d want 0/0", sec_lo, dut.sub_cnt_reg); end
    @(negedge clkin); rst_n = 1'b1;
    tick(50);
    compared++; if (running !== 1'b0) begin mismatched++; $display("FAIL hold_running: got %b want 0", running); end
    compared++; if (sec_lo !== 4'd0 || wrap !== 1'b0) begin mismatched++; $display("FAIL hold_outputs: got sec_lo=%0d wrap=%b want 0/0", sec_lo, wrap); end
    @(negedge clkin); start_btn = 1'b0;
    press_start();
    compared++; if (running !== 1'b1) begin mismatched++; $display("FAIL hold_repress: got %b want 1", running); end
    $display("hold_reset: running after repress=%b", running);
  endtask

  task automatic test_wrap();
    press_clr();
    press_start();
    tick(3016);
    compared++; if ({min_hi, min_lo, sec_hi, sec_lo} !== 16'h1234) begin mismatched++; $display("FAIL wrap_1234: got %h want 1234", {min_hi, min_lo, sec_hi, sec_lo}); end
`ifdef STOPWATCH_SEG_EN
    compared++; if ({seg3, seg2, seg1, seg0} !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}) begin mismatched++; $display("FAIL seg_1234: got %b %b %b %b want 1111001 0100100 0110000 0011001", seg3, seg2, seg1, seg0); end
`endif
    tick(11376);
    compared++; if ({min_hi, min_lo, sec_hi, sec_lo} !== 16'h5958) begin mismatched++; $display("FAIL wrap_5958: got %h want 5958", {min_hi, min_lo, sec_hi, sec_lo}); end
    compared++; if (wrap_cnt !== 0) begin mismatched++; $display("FAIL wrap_early: got %0d pulses want 0", wrap_cnt); end
    tick(8);
    @(negedge clkin);
    compared++; if ({min_hi, min_lo, sec_hi, sec_lo} !== 16'h0000) begin mismatched++; $display("FAIL wrap_0000: got %h want 0000", {min_hi, min_lo, sec_hi, sec_lo}); end
    compared++; if (wrap_cnt !== 1) begin mismatched++; $display("FAIL wrap_pulse_cycles: got %0d want 1", wrap_cnt); end
    compared++; if (wrap !== 1'b0) begin mismatched++; $display("FAIL wrap_low_after: got %b want 0", wrap); end
    $display("wrap: 59:58 + 2s -> %0d%0d:%0d%0d, wrap cycles=%0d", min_hi, min_lo, sec_hi, sec_lo, wrap_cnt);
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_start_on_last_tick();
    test_clear();
    test_hold_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
